decode_stage: RTL

Registered, parameterised decode stage for the pipelined processor, sitting between fetch and execute. It extracts register-read addresses, branch flags and the extended immediate from each instruction. It carries the instruction to execute through a valid/ready pipeline register. It also inserts a configurable number of load-use bubbles when the instruction in execute is a `lw` whose destination feeds the incoming instruction.

---
 rtl/decode_pkg.sv | 46 ++++
 rtl/decode_hazard.sv | 61 ++++++
 rtl/decode_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_pkg
// Purpose  : Opcodes, instruction field positions and register-use helpers
//            shared by the decode stage and its hazard unit.
// Revision : 1.0
// ============================================================================
package decode_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam int c_opc_hi = 31;
    localparam int c_opc_lo = 27;
    localparam int c_rd_hi  = 26;
    localparam int c_rd_lo  = 22;
    localparam int c_rs_hi  = 21;
    localparam int c_rs_lo  = 17;
    localparam int c_rt_hi  = 16;
    localparam int c_rt_lo  = 12;

    // These opcodes read rd as their second source instead of rt.
    function automatic logic rd_rt(input logic [4:0] opcode);
        return (opcode == OP_BNE) || (opcode == OP_JR) ||
               (opcode == OP_BLT) || (opcode == OP_SW);
    endfunction

    function automatic logic uses_s1(input logic [4:0] opcode);
        return !((opcode == OP_J) || (opcode == OP_JAL) ||
                 (opcode == OP_SETX) || (opcode == OP_BEX));
    endfunction

    function automatic logic uses_s2(input logic [4:0] opcode);
        return (opcode == OP_RTYPE) || rd_rt(opcode);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_hazard.sv
`default_nettype none
// ============================================================================
// Module   : decode_hazard
// Purpose  : Load-use comparator and bubble counter for the decode stage.
// Revision : 1.0
// ============================================================================
module decode_hazard
    import decode_pkg::*;
#(
    parameter int LOAD_USE_STALLS = 1
)
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       advance,
    input  logic       in_valid,
    input  logic       out_valid,
    input  logic [4:0] ex_opcode,
    input  logic [4:0] ex_rd,
    input  logic [4:0] read_reg_s1,
    input  logic [4:0] read_reg_s2,
    input  logic       uses_s1,
    input  logic       uses_s2,
    output logic       hazard,
    output logic       bubble
);

    localparam logic [1:0] c_stall_reload = 2'(LOAD_USE_STALLS - 1);

    logic [1:0] r_stall_cnt;
    logic       w_ex_is_lw;
    logic       w_match_s1;
    logic       w_match_s2;
    logic       w_stall_busy;

    assign w_ex_is_lw   = out_valid && (ex_opcode == OP_LW) && (ex_rd != 5'd0);
    assign w_match_s1   = uses_s1 && (ex_rd == read_reg_s1);
    assign w_match_s2   = uses_s2 && (ex_rd == read_reg_s2);
    assign w_stall_busy = (r_stall_cnt != 2'd0);

    assign hazard = in_valid && w_ex_is_lw && (w_match_s1 || w_match_s2);
    // A bubble is owed either for a fresh hazard or for the remainder of one.
    assign bubble = hazard || w_stall_busy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= 2'd0;
        end else if (flush) begin
            r_stall_cnt <= 2'd0;
        end else if (advance) begin
            if (w_stall_busy) begin
                r_stall_cnt <= r_stall_cnt - 2'd1;
            end else if (hazard) begin
                r_stall_cnt <= c_stall_reload;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : Registered decode stage with valid/ready handshake and load-use
//            bubble insertion. Define DECODE_SIGN_EXT_EN for a sign-extended
//            immediate; the default zero-extends it.
// Revision : 1.0
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int IMM_W           = 17,
    parameter int LOAD_USE_STALLS = 1
)
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc,
    output logic [4:0]        read_reg_s1,
    output logic [4:0]        read_reg_s2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_pc,
    output logic              out_bne,
    output logic              out_blt,
    output logic [DATA_W-1:0] out_imm
);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_instr;
    logic [DATA_W-1:0] r_out_pc;
    logic              r_out_bne;
    logic              r_out_blt;
    logic [DATA_W-1:0] r_out_imm;

    logic [4:0]        w_opcode;
    logic [IMM_W-1:0]  w_imm_field;
    logic [DATA_W-1:0] w_imm;
    logic              w_advance;
    logic              w_hazard;
    logic              w_bubble;
    logic              w_accept;

    assign w_opcode    = in_instr[c_opc_hi:c_opc_lo];
    assign w_imm_field = in_instr[IMM_W-1:0];

    assign read_reg_s1 = in_instr[c_rs_hi:c_rs_lo];
    assign read_reg_s2 = rd_rt(w_opcode) ? in_instr[c_rd_hi:c_rd_lo]
                                         : in_instr[c_rt_hi:c_rt_lo];

`ifdef DECODE_SIGN_EXT_EN
    assign w_imm = {{(DATA_W-IMM_W){w_imm_field[IMM_W-1]}}, w_imm_field};
`else
    assign w_imm = {{(DATA_W-IMM_W){1'b0}}, w_imm_field};
`endif

    assign w_advance = out_ready || !r_out_valid;
    assign in_ready  = w_advance && !w_bubble && !flush;
    assign w_accept  = in_valid && in_ready;

    decode_hazard #(
        .LOAD_USE_STALLS (LOAD_USE_STALLS)
    ) u_hazard (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .advance     (w_advance),
        .in_valid    (in_valid),
        .out_valid   (r_out_valid),
        .ex_opcode   (r_out_instr[c_opc_hi:c_opc_lo]),
        .ex_rd       (r_out_instr[c_rd_hi:c_rd_lo]),
        .read_reg_s1 (read_reg_s1),
        .read_reg_s2 (read_reg_s2),
        .uses_s1     (uses_s1(w_opcode)),
        .uses_s2     (uses_s2(w_opcode)),
        .hazard      (w_hazard),
        .bubble      (w_bubble)
    );

    // Bubbles and empty cycles clear valid but leave the payload untouched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
            r_out_bne   <= 1'b0;
            r_out_blt   <= 1'b0;
            r_out_imm   <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_instr <= in_instr;
                r_out_pc    <= in_pc;
                r_out_bne   <= (w_opcode == OP_BNE);
                r_out_blt   <= (w_opcode == OP_BLT);
                r_out_imm   <= w_imm;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;
    assign out_bne   = r_out_bne;
    assign out_blt   = r_out_blt;
    assign out_imm   = r_out_imm;

endmodule
`default_nettype wire
